// File: rtl/spi_ram_burst.sv
// ----------------------------------------------------------------------------
// spi_ram_burst
//
// Purpose:
//   Single-port word RAM that sits behind an SPI slave shift register. Each
//   valid receive word carries a two-bit opcode and a payload. The opcodes
//   load the write pointer, write a word, load the read pointer, or read a
//   word. Both pointers can auto-increment after each data access, which
//   gives burst transfers. A SET with an address beyond the memory depth
//   leaves the pointer unchanged and raises a sticky error flag.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   rx_valid  in   din carries a command this cycle
//   din       in   {opcode[1:0], payload[WORD_SIZE-1:0]}
//   tx_valid  out  one-cycle pulse after each READ
//   dout      out  last word read, held until the next READ
//   err       out  sticky out-of-range SET flag, cleared only by reset
// ----------------------------------------------------------------------------
module spi_ram_burst #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int WORD_SIZE = 8,
    parameter int AUTO_INC  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_valid,
    input  logic [WORD_SIZE+1:0] din,
    output logic                 tx_valid,
    output logic [WORD_SIZE-1:0] dout,
    output logic                 err
);

    localparam int DIN_WIDTH = WORD_SIZE + 2;

    // One extra bit so that MEM_DEPTH = 2^ADDR_SIZE is representable.
    localparam logic [ADDR_SIZE:0]   DEPTH_LIM = (ADDR_SIZE+1)'(MEM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = (ADDR_SIZE)'(MEM_DEPTH - 1);
    localparam logic [ADDR_SIZE-1:0] ADDR_ONE  = (ADDR_SIZE)'(1);

    typedef enum logic [1:0] {
        OP_SET_WADDR = 2'b00,
        OP_WRITE     = 2'b01,
        OP_SET_RADDR = 2'b10,
        OP_READ      = 2'b11
    } opcode_e;

    logic [WORD_SIZE-1:0] mem [0:MEM_DEPTH-1];

    logic [ADDR_SIZE-1:0] waddr_q, waddr_d;
    logic [ADDR_SIZE-1:0] raddr_q, raddr_d;
    logic [WORD_SIZE-1:0] dout_q, dout_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 err_q, err_d;
    logic                 mem_we;

    opcode_e              opcode;
    logic [WORD_SIZE-1:0] payload;
    logic [ADDR_SIZE-1:0] set_addr;
    logic                 set_in_range;

    assign opcode       = opcode_e'(din[DIN_WIDTH-1:DIN_WIDTH-2]);
    assign payload      = din[WORD_SIZE-1:0];
    assign set_addr     = payload[ADDR_SIZE-1:0];
    assign set_in_range = ({1'b0, set_addr} < DEPTH_LIM);

    // Post-access pointer update: wraps from the last word back to 0 so a
    // pointer can never leave the valid range.
    function automatic logic [ADDR_SIZE-1:0] bump(input logic [ADDR_SIZE-1:0] p);
        if (AUTO_INC == 0)
            return p;
        else if (p == LAST_ADDR)
            return '0;
        else
            return p + ADDR_ONE;
    endfunction

    always_comb begin
        waddr_d    = waddr_q;
        raddr_d    = raddr_q;
        dout_d     = dout_q;
        tx_valid_d = 1'b0;
        err_d      = err_q;
        mem_we     = 1'b0;
        if (rx_valid) begin
            case (opcode)
                OP_SET_WADDR: begin
                    if (set_in_range) waddr_d = set_addr;
                    else              err_d   = 1'b1;
                end
                OP_WRITE: begin
                    mem_we  = 1'b1;
                    waddr_d = bump(waddr_q);
                end
                OP_SET_RADDR: begin
                    if (set_in_range) raddr_d = set_addr;
                    else              err_d   = 1'b1;
                end
                OP_READ: begin
                    dout_d     = mem[raddr_q];
                    tx_valid_d = 1'b1;
                    raddr_d    = bump(raddr_q);
                end
                default: ;
            endcase
        end
    end

    // Storage has no reset; writes are suppressed while reset is held so
    // that reset leaves the contents untouched.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n)
            mem[waddr_q] <= payload;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr_q    <= '0;
            raddr_q    <= '0;
            dout_q     <= '0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            waddr_q    <= waddr_d;
            raddr_q    <= raddr_d;
            dout_q     <= dout_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
        end
    end

    assign tx_valid = tx_valid_q;
    assign dout     = dout_q;
    assign err      = err_q;

endmodule

// File: tb/tb_spi_ram_burst.sv
// ----------------------------------------------------------------------------
// tb_spi_ram_burst
//
// Drives three copies of spi_ram_burst from one command stream:
//   dut0: depth 256, auto-increment
//   dut1: depth 200, auto-increment (exercises the range error)
//   dut2: depth 256, pointers hold
// A behavioural model keeps a plain array and integer pointers per copy and
// predicts tx_valid/dout/err after every edge. Hand-written sequences and a
// table of vectors add fixed expected values on top of the model.
// ----------------------------------------------------------------------------
module tb_spi_ram_burst;

    localparam logic [1:0] OP_SW = 2'b00;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_SR = 2'b10;
    localparam logic [1:0] OP_RD = 2'b11;

    logic       clk;
    logic       rst_n;
    logic       rxValid;
    logic [9:0] din;
    logic       txV   [3];
    logic [7:0] doutV [3];
    logic       errV  [3];

    int compared;
    int mismatched;

    // Reference model state, one slot per DUT copy.
    int         mDepth [3] = '{256, 200, 256};
    bit         mInc   [3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0] mMem   [3][256];
    bit         mWr    [3][256];
    int         mWaddr [3];
    int         mRaddr [3];
    logic [7:0] mDout  [3];
    bit         mDoutKnown [3];
    bit         mTx    [3];
    bit         mErr   [3];

    typedef struct {
        bit         rv;
        logic [1:0] op;
        logic [7:0] pl;
        bit         expTx;
        logic [7:0] expDout;
        bit         expErr;
    } vec_t;

    vec_t tbl [17];

    spi_ram_burst #(.MEM_DEPTH(256), .ADDR_SIZE(8), .WORD_SIZE(8), .AUTO_INC(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .rx_valid(rxValid), .din(din),
        .tx_valid(txV[0]), .dout(doutV[0]), .err(errV[0]));

    spi_ram_burst #(.MEM_DEPTH(200), .ADDR_SIZE(8), .WORD_SIZE(8), .AUTO_INC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx_valid(rxValid), .din(din),
        .tx_valid(txV[1]), .dout(doutV[1]), .err(errV[1]));

    spi_ram_burst #(.MEM_DEPTH(256), .ADDR_SIZE(8), .WORD_SIZE(8), .AUTO_INC(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .rx_valid(rxValid), .din(din),
        .tx_valid(txV[2]), .dout(doutV[2]), .err(errV[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(bit rv, logic [1:0] op, logic [7:0] pl,
                                   bit tx, logic [7:0] dq, bit er);
        vec_t v;
        v.rv = rv; v.op = op; v.pl = pl;
        v.expTx = tx; v.expDout = dq; v.expErr = er;
        return v;
    endfunction

    task automatic compareVal(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int c = 0; c < 3; c++) begin
            mWaddr[c] = 0; mRaddr[c] = 0;
            mDout[c] = 8'h00; mDoutKnown[c] = 1'b1;
            mTx[c] = 1'b0; mErr[c] = 1'b0;
        end
    endtask

    // Effect of one sampled command on every model copy.
    task automatic modelStep(input bit rv, input logic [1:0] op, input logic [7:0] pl);
        for (int c = 0; c < 3; c++) begin
            mTx[c] = 1'b0;
            if (rv) begin
                case (op)
                    OP_SW: if (int'(pl) < mDepth[c]) mWaddr[c] = int'(pl); else mErr[c] = 1'b1;
                    OP_SR: if (int'(pl) < mDepth[c]) mRaddr[c] = int'(pl); else mErr[c] = 1'b1;
                    OP_WR: begin
                        mMem[c][mWaddr[c]] = pl;
                        mWr[c][mWaddr[c]]  = 1'b1;
                        if (mInc[c]) mWaddr[c] = (mWaddr[c] + 1) % mDepth[c];
                    end
                    default: begin
                        mDout[c]      = mMem[c][mRaddr[c]];
                        mDoutKnown[c] = mWr[c][mRaddr[c]];
                        mTx[c]        = 1'b1;
                        if (mInc[c]) mRaddr[c] = (mRaddr[c] + 1) % mDepth[c];
                    end
                endcase
            end
        end
    endtask

    task automatic checkOutput();
        for (int c = 0; c < 3; c++) begin
            compareVal($sformatf("tx_valid[%0d]", c), 32'(txV[c]), 32'(mTx[c]));
            compareVal($sformatf("err[%0d]", c), 32'(errV[c]), 32'(mErr[c]));
            if (mDoutKnown[c])
                compareVal($sformatf("dout[%0d]", c), 32'(doutV[c]), 32'(mDout[c]));
        end
    endtask

    // Called at a falling edge; returns at the next falling edge after the
    // command has been sampled and outputs checked against the model.
    task automatic applyStimulus(input bit rv, input logic [1:0] op, input logic [7:0] pl);
        rxValid = rv;
        din     = {op, pl};
        @(posedge clk);
        modelStep(rv, op, pl);
        @(negedge clk);
        checkOutput();
        rxValid = 1'b0;
    endtask

    // Drops rst_n between edges while garbage commands are being driven.
    task automatic asyncReset();
        logic [9:0] g;
        g = 10'($urandom);
        rxValid = 1'b1;
        din     = g;
        @(posedge clk);
        modelStep(1'b1, g[9:8], g[7:0]);
        #2 rst_n = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            compareVal($sformatf("rst tx_valid[%0d]", c), 32'(txV[c]), 32'd0);
            compareVal($sformatf("rst dout[%0d]", c), 32'(doutV[c]), 32'd0);
            compareVal($sformatf("rst err[%0d]", c), 32'(errV[c]), 32'd0);
        end
        modelReset();
        @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        rxValid = 1'b0;
        checkOutput();
    endtask

    initial begin
        logic [1:0] op;
        logic [7:0] pl;
        compared   = 0;
        mismatched = 0;
        rst_n   = 1'b0;
        rxValid = 1'b0;
        din     = '0;
        for (int c = 0; c < 3; c++)
            for (int a = 0; a < 256; a++) begin
                mWr[c][a]  = 1'b0;
                mMem[c][a] = 8'h00;
            end
        modelReset();

        // Burst and wrap vectors, expected values for dut0 (depth 256, inc).
        tbl[0]  = mkVec(1, OP_SW, 8'h10, 0, 8'h00, 0);
        tbl[1]  = mkVec(1, OP_WR, 8'hA1, 0, 8'h00, 0);
        tbl[2]  = mkVec(1, OP_WR, 8'hA2, 0, 8'h00, 0);
        tbl[3]  = mkVec(1, OP_WR, 8'hA3, 0, 8'h00, 0);
        tbl[4]  = mkVec(1, OP_SR, 8'h10, 0, 8'h00, 0);
        tbl[5]  = mkVec(1, OP_RD, 8'h00, 1, 8'hA1, 0);
        tbl[6]  = mkVec(1, OP_RD, 8'h00, 1, 8'hA2, 0);
        tbl[7]  = mkVec(1, OP_RD, 8'h00, 1, 8'hA3, 0);
        tbl[8]  = mkVec(0, OP_RD, 8'h00, 0, 8'hA3, 0);
        tbl[9]  = mkVec(1, OP_SW, 8'hFF, 0, 8'hA3, 0);
        tbl[10] = mkVec(1, OP_WR, 8'h55, 0, 8'hA3, 0);
        tbl[11] = mkVec(1, OP_WR, 8'h66, 0, 8'hA3, 0);
        tbl[12] = mkVec(1, OP_SR, 8'hFF, 0, 8'hA3, 0);
        tbl[13] = mkVec(1, OP_RD, 8'h00, 1, 8'h55, 0);
        tbl[14] = mkVec(1, OP_RD, 8'h00, 1, 8'h66, 0);
        tbl[15] = mkVec(1, OP_WR, 8'h77, 0, 8'h66, 0);
        tbl[16] = mkVec(1, OP_RD, 8'h00, 1, 8'h77, 0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checkOutput();

        // Reset in the middle of garbage traffic, then both pointers at 0.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'($urandom), 8'($urandom));
        asyncReset();
        applyStimulus(1'b1, OP_WR, 8'h3C);
        applyStimulus(1'b1, OP_RD, 8'h00);
        compareVal("post-reset read tx", 32'(txV[0]), 32'd1);
        compareVal("post-reset read dout", 32'(doutV[0]), 32'h3C);

        // Range check on the depth-200 copy, including the last legal address.
        applyStimulus(1'b1, OP_SW, 8'h05);
        applyStimulus(1'b1, OP_SW, 8'hC7);
        compareVal("C7 in range err", 32'(errV[1]), 32'd0);
        applyStimulus(1'b1, OP_SW, 8'h05);
        applyStimulus(1'b1, OP_SW, 8'hC8);
        compareVal("C8 out of range err", 32'(errV[1]), 32'd1);
        compareVal("C8 legal on depth 256", 32'(errV[0]), 32'd0);
        applyStimulus(1'b1, OP_WR, 8'h77);
        applyStimulus(1'b1, OP_SR, 8'h05);
        applyStimulus(1'b1, OP_RD, 8'h00);
        compareVal("write after bad SET lands at old waddr", 32'(doutV[1]), 32'h77);
        compareVal("err sticky", 32'(errV[1]), 32'd1);

        // Pointers hold when auto-increment is off.
        applyStimulus(1'b1, OP_SW, 8'h05);
        applyStimulus(1'b1, OP_WR, 8'h11);
        applyStimulus(1'b1, OP_WR, 8'h22);
        applyStimulus(1'b1, OP_SR, 8'h05);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, OP_RD, 8'h00);
            compareVal($sformatf("no-inc read %0d", i), 32'(doutV[2]), 32'h22);
        end

        // Table-driven burst and wrap sequence.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(tbl[i].rv, tbl[i].op, tbl[i].pl);
            compareVal($sformatf("vec%0d tx_valid", i), 32'(txV[0]), 32'(tbl[i].expTx));
            compareVal($sformatf("vec%0d dout", i), 32'(doutV[0]), 32'(tbl[i].expDout));
            compareVal($sformatf("vec%0d err", i), 32'(errV[0]), 32'(tbl[i].expErr));
        end

        // Random traffic with idle gaps and addresses biased toward the ends.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) asyncReset();
            op = 2'($urandom_range(0, 3));
            if ((op == OP_SW || op == OP_SR) && $urandom_range(0, 2) == 0)
                pl = 8'(190 + $urandom_range(0, 65));
            else
                pl = 8'($urandom);
            applyStimulus($urandom_range(0, 9) < 7, op, pl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/spi_ram_burst.md
# spi_ram_burst

Parametrised command-decoded single-port RAM that sits behind the SPI slave shift register and consumes its `rx_valid`/`din` words. It provides independent write and read address pointers, optional post-access auto-increment for burst transfers, and a sticky range-error flag. Reads return data with a one-cycle `tx_valid` pulse for the SPI transmit path.

## Interface
- `MEM_DEPTH`, 256: number of words; any value from 2 to 2^ADDR_SIZE.
- `ADDR_SIZE`, 8: address pointer width; must be ≤ WORD_SIZE.
- `WORD_SIZE`, 8: data word width; also the payload width of `din`.
- `AUTO_INC`, 1: 1 = pointer increments after each data write/read; 0 = pointer holds.
- Derived, not overridable: `DIN_WIDTH` = WORD_SIZE+2.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  `din` is valid this cycle; one command per high cycle.
- `din`  in  DIN_WIDTH  [DIN_WIDTH-1:DIN_WIDTH-2] = opcode, [WORD_SIZE-1:0] = payload.
- `tx_valid`  out  1  one-cycle pulse per completed read.
- `dout`  out  WORD_SIZE  read data, held until the next read.
- `err`  out  1  sticky out-of-range address flag.

## Operation
- Internal state: `mem[0:MEM_DEPTH-1]`, `waddr`, `raddr` (ADDR_SIZE each).
- Opcodes are decoded only when `rx_valid`=1. With `rx_valid`=0 all state holds and `tx_valid`=0.
  - 00 SET_WADDR: if payload[ADDR_SIZE-1:0] < MEM_DEPTH, `waddr` takes it; otherwise `waddr` holds and `err` is set to 1.
  - 01 WRITE: `mem[waddr]` takes payload. If AUTO_INC=1, `waddr` takes `waddr`+1, or 0 when `waddr`=MEM_DEPTH-1.
  - 10 SET_RADDR: same as SET_WADDR, applied to `raddr`.
  - 11 READ: `dout` takes `mem[raddr]` and `tx_valid` is 1 for the next cycle. If AUTO_INC=1, `raddr` increments with the same wrap rule.
- Payload bits above ADDR_SIZE are ignored for SET opcodes. They are not range-checked.
- `dout` changes only on READ; other opcodes do not clear it.
- The write and read pointers are independent. A SET of one pointer never changes the other.
- `err` is set only by out-of-range SET commands and clears only on reset. When MEM_DEPTH = 2^ADDR_SIZE, `err` never asserts.
- `mem` is not reset; its contents are undefined until written.

## Timing
- Reset, asynchronous on the `rst_n` falling edge, independent of `clk`: `tx_valid`=0, `dout`=0, `err`=0, `waddr`=0, `raddr`=0. `mem` is untouched.
- Reset asserted mid-burst aborts the burst. After release, both pointers are 0 and the first command is accepted on the first rising edge with `rst_n`=1.
- All outputs are registered and update on the rising edge that samples the command.
- READ latency: `dout`/`tx_valid` are valid in the cycle after the sampling edge.
- Back-to-back READs: `tx_valid` stays high on consecutive cycles, and `dout` steps through successive addresses.
- WRITE then READ of the same address on the next edge returns the newly written word; there is no stale read.
- Wrap-around: the pointer goes MEM_DEPTH-1 → 0 with no error and no stall. The pointer never holds a value ≥ MEM_DEPTH.
- Throughput: one command per cycle, no backpressure.

## Test plan
- Reset: drive garbage, then pulse `rst_n` low between clock edges → `tx_valid`/`dout`/`err` go 0 immediately. READ after SET_RADDR 0 succeeds with `tx_valid` pulsing.
- Burst write/read (AUTO_INC=1, depth 256): SET_WADDR 0x10, WRITE 0xA1, 0xA2, 0xA3, SET_RADDR 0x10, READ ×3 → `dout`=A1, A2, A3 on consecutive cycles with `tx_valid`=1,1,1, then 0.
- Wrap: SET_WADDR 0xFF, WRITE 0x55, WRITE 0x66 → mem[0xFF]=0x55, mem[0x00]=0x66. READ from 0xFF, twice → 0x55, 0x66.
- Range error (MEM_DEPTH=200): SET_WADDR 0xC8 → `err`=1 and `waddr` unchanged. WRITE 0x77 lands at the previous `waddr`. `err` stays 1 until reset.
- AUTO_INC=0: SET_RADDR 5, then three READs → the same word each time. Two WRITEs → only the last value remains at `waddr`.
- Idle gaps: `rx_valid`=0 between commands for random cycles → no state change, `tx_valid`=0, `dout` held.
